// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU with valid/ready handshake, iterative multiply and restoring divide
// Single-cycle ops resolve at acceptance; MUL/DIVU/REMU run WIDTH iterations in ITER.
module alu_multicycle #(
  parameter int WIDTH            = 32,
  parameter int ALUControl_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            SrcA,
  input  logic [WIDTH-1:0]            SrcB,
  input  logic [ALUControl_WIDTH-1:0] ALUControl,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            ALUResult,
  output logic                        Zero_flag,
  output logic                        Overflow_flag,
  output logic                        DivByZero_flag
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t                state, state_next;
  logic                  started;
  logic [3:0]            op;
  logic [CW-1:0]         cnt;
  logic [WIDTH-1:0]      acc;
  logic [WIDTH-1:0]      md;
  logic [WIDTH-1:0]      mq;
  logic [WIDTH-1:0]      result;
  logic                  zero_r, ovf_r, dbz_r;

  logic                  accept;
  logic                  is_div, is_iter, is_div0;
  logic [SHW-1:0]        shamt;
  logic [WIDTH-1:0]      sum, diff;
  logic [WIDTH-1:0]      sc_result;
  logic                  sc_ovf;
  logic [WIDTH-1:0]      mul_acc;
  logic [WIDTH:0]        div_shift;
  logic                  div_ge;
  logic [WIDTH-1:0]      div_sub, div_rem, div_quo;
  logic [WIDTH-1:0]      iter_result;

  assign in_ready       = started && (state == IDLE);
  assign out_valid      = (state == DONE);
  assign ALUResult      = result;
  assign Zero_flag      = zero_r;
  assign Overflow_flag  = ovf_r;
  assign DivByZero_flag = dbz_r;

  assign accept  = in_valid && in_ready;
  assign is_div  = (ALUControl == OP_DIVU) || (ALUControl == OP_REMU);
  assign is_div0 = is_div && (SrcB == '0);
  assign is_iter = (ALUControl == OP_MUL) || (is_div && !is_div0);
  assign shamt   = SrcB[SHW-1:0];
  assign sum     = SrcA + SrcB;
  assign diff    = SrcA - SrcB;

  // Single-cycle results are computed straight from the inputs at acceptance.
  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (ALUControl)
      OP_AND:  sc_result = SrcA & SrcB;
      OP_OR:   sc_result = SrcA | SrcB;
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_XOR:  sc_result = SrcA ^ SrcB;
      OP_SUB: begin
        sc_result = diff;
        sc_ovf    = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_NOR:  sc_result = ~(SrcA | SrcB);
      OP_SLL:  sc_result = SrcA << shamt;
      OP_SRL:  sc_result = SrcA >> shamt;
      OP_SRA:  sc_result = $signed(SrcA) >>> shamt;
      OP_DIVU: sc_result = '1;
      OP_REMU: sc_result = SrcA;
      default: sc_result = '0;
    endcase
  end

  // One iteration step; md/mq are multiplicand/multiplier for MUL, divisor/quotient for divide.
  always_comb begin
    mul_acc     = acc + (mq[0] ? md : '0);
    div_shift   = {acc, mq[WIDTH-1]};
    div_ge      = div_shift[WIDTH] || (div_shift[WIDTH-1:0] >= md);
    div_sub     = div_shift[WIDTH-1:0] - md;
    div_rem     = div_ge ? div_sub : div_shift[WIDTH-1:0];
    div_quo     = {mq[WIDTH-2:0], div_ge};
    iter_result = '0;
    if (op == OP_MUL)       iter_result = mul_acc;
    else if (op == OP_DIVU) iter_result = div_quo;
    else                    iter_result = div_rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = is_iter ? ITER : DONE;
      ITER: if (cnt == LAST) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= '0;
      cnt    <= '0;
      acc    <= '0;
      md     <= '0;
      mq     <= '0;
      result <= '0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op  <= ALUControl;
            cnt <= '0;
            acc <= '0;
            if (ALUControl == OP_MUL) begin
              md <= SrcA;
              mq <= SrcB;
            end else begin
              md <= SrcB;
              mq <= SrcA;
            end
            if (!is_iter) begin
              result <= sc_result;
              zero_r <= (sc_result == '0);
              ovf_r  <= sc_ovf;
              dbz_r  <= is_div0;
            end
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (op == OP_MUL) begin
            acc <= mul_acc;
            md  <= md << 1;
            mq  <= mq >> 1;
          end else begin
            acc <= div_rem;
            mq  <= div_quo;
          end
          if (cnt == LAST) begin
            result <= iter_result;
            zero_r <= (iter_result == '0);
            ovf_r  <= 1'b0;
            dbz_r  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64 (power of two).
REQ-002 SHALL provide parameter ALUControl_WIDTH, default 4, opcode width; fixed at 4.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide port in_valid  input  1  operation request valid.
REQ-006 SHALL provide port in_ready  output  1  block can accept a request.
REQ-007 SHALL provide ports SrcA, SrcB  input  WIDTH  operands.
REQ-008 SHALL provide port ALUControl  input  4  opcode.
REQ-009 SHALL provide port out_valid  output  1  result valid.
REQ-010 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-011 SHALL provide port ALUResult  output  WIDTH  result.
REQ-012 SHALL provide ports Zero_flag, Overflow_flag, DivByZero_flag  output  1 each  status flags qualified by out_valid.

Function
REQ-013 SHALL decode: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB, 0101 MUL, 0110 SLT (signed), 0111 SLTU, 1000 NOR, 1001 SLL, 1010 SRL, 1011 SRA, 1100 DIVU, 1101 REMU; 1110/1111 -> result 0, single-cycle.
REQ-014 SHALL implement FSM states IDLE, ITER, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL accept a request on a cycle with in_valid & in_ready, capturing SrcA, SrcB, ALUControl; later input changes SHALL NOT affect the operation.
REQ-016 Single-cycle ops (all except MUL, DIVU, REMU): IDLE -> DONE, out_valid asserted the cycle after acceptance (latency 1).
REQ-017 MUL: iterative shift-add, IDLE -> ITER for exactly WIDTH cycles -> DONE; latency WIDTH+1; result = low WIDTH bits of unsigned product (equals signed low half).
REQ-018 DIVU/REMU: iterative restoring divide, WIDTH cycles in ITER, latency WIDTH+1; DIVU gives quotient, REMU remainder, both unsigned.
REQ-019 Divide with SrcB = 0: SHALL skip ITER (latency 1); DIVU result all ones, REMU result = SrcA, DivByZero_flag = 1.
REQ-020 Shifts SHALL use SrcB[log2(WIDTH)-1:0] as amount, upper SrcB bits ignored; SRA replicates SrcA MSB.
REQ-021 SLT/SLTU SHALL return 1 or 0 zero-extended to WIDTH.
REQ-022 ADD/SUB SHALL wrap modulo 2^WIDTH; Overflow_flag = two's-complement signed overflow for ADD/SUB, 0 for all other ops.
REQ-023 Zero_flag SHALL equal (ALUResult == 0), registered with the result.
REQ-024 DONE SHALL hold ALUResult and all flags stable while out_ready = 0; DONE -> IDLE on out_ready = 1.
REQ-025 In_valid while not IDLE SHALL be ignored (no queueing); next acceptance earliest the cycle after DONE exits.
REQ-026 ITER cycle counter SHALL be log2(WIDTH)+1 bits and SHALL clear on every acceptance.

Reset
REQ-027 rst_n = 0 SHALL asynchronously force state IDLE, ALUResult = 0, all flags 0, out_valid = 0, internal registers 0.
REQ-028 in_ready SHALL be 0 while rst_n = 0 and 1 from the first rising clk edge after release.
REQ-029 Reset during ITER or DONE SHALL abort the operation; no result SHALL be presented afterwards.

Verification
REQ-030 WIDTH=32, ADD 0x7FFFFFFF+0x00000001, out_ready=1 -> out_valid 1 cycle after accept, result 0x80000000, Overflow_flag=1, Zero_flag=0.
REQ-031 MUL 0x0000FFFF*0x00010001 -> out_valid exactly 33 cycles after accept, result 0xFFFFFFFF; in_ready=0 throughout.
REQ-032 DIVU 100/7 then REMU 100/7 -> 14 then 2, each latency 33; DIVU 5/0 -> latency 1, result 0xFFFFFFFF, DivByZero_flag=1.
REQ-033 SUB 5-5 with out_ready held 0 for 4 cycles -> result 0, Zero_flag=1 held stable 4 cycles, IDLE the cycle after out_ready=1.
REQ-034 rst_n pulsed low at ITER cycle 10 of MUL -> out_valid never asserts, outputs 0, next ADD 2+3 returns 5.
REQ-035 WIDTH=8 regression: SRA 0x80 by 3 -> 0xF0; SLT 0xFF vs 0x01 -> 1; SLTU same -> 0; MUL latency 9.
